// File: rtl/sha256_round_sequencer.sv
// -----------------------------------------------------------------------------
// sha256_round_sequencer
//
// Sequences one SHA-256 512-bit block. It collects 16 message words, runs the
// compression rounds and drives the shared `block` toggle that tells the
// external H0..H7 registers to load their IV (first toggle) or to accumulate
// (second toggle).
//
// Ports
//   clk        in    rising-edge clock
//   rst_n      in    asynchronous active-low reset
//   start      in    one-cycle pulse, begins a block (only honoured in IDLE)
//   msg_valid  in    msg_word is valid
//   msg_word   in    message word W[t], t=0..15, big-endian word order
//   msg_ready  out   registered; a word is taken on msg_valid & msg_ready
//   h_in       in    current {H0..H7}, H0 in the MSBs
//   block      out   level toggle to the H registers
//   work_out   out   {a,b,c,d,e,f,g,h}, always the working-variable registers
//   busy       out   high in every state except IDLE
//   done       out   one-cycle pulse after the accumulate toggle
//
// Optional build macro: SHA256_MIDSTATE_EN
//   Adds mid_use (sampled with start) and mid_state; when mid_use was high,
//   a..h load from mid_state instead of h_in.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sha256_round_sequencer #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
`ifdef SHA256_MIDSTATE_EN
  input  logic         mid_use,
  input  logic [255:0] mid_state,
`endif
  input  logic         msg_valid,
  input  logic [31:0]  msg_word,
  output logic         msg_ready,
  input  logic [255:0] h_in,
  output logic         block,
  output logic [255:0] work_out,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_SETTLE = 3'd2,
    S_RECV   = 3'd3,
    S_RUN    = 3'd4,
    S_FIN    = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [6:0] LAST_RND  = 7'(ROUNDS - 1);
  localparam logic [6:0] LAST_WORD = 7'd15;

  // Round constants, K[0] in the MSBs.
  localparam logic [2047:0] K_ROM = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t         state_q;
  logic [255:0]   st_q;          // {a,b,c,d,e,f,g,h}
  logic [31:0]    w_q [16];      // w_q[0] is W[t] for the current round
  logic [6:0]     cnt_q;         // word counter in RECV, round counter in RUN
  logic           block_q;
  logic           ready_q;
  logic           busy_q;
  logic           done_q;
`ifdef SHA256_MIDSTATE_EN
  logic           mid_use_q;
`endif

  logic [31:0]    a_s, b_s, c_s, d_s, e_s, f_s, g_s, h_s;
  logic [10:0]    k_base_s;
  logic [31:0]    k_s;
  logic [31:0]    t1_d, t2_d;
  logic [255:0]   round_d;
  logic [31:0]    w_new_d;

  assign {a_s, b_s, c_s, d_s, e_s, f_s, g_s, h_s} = st_q;

  // K[t] sits at bit 2047-32t downwards in the packed ROM.
  assign k_base_s = 11'd2047 - {cnt_q[5:0], 5'd0};
  assign k_s      = K_ROM[k_base_s -: 32];

  // One compression round and the next schedule word (W[t+16]).
  always_comb begin
    t1_d    = h_s + big_sig1(e_s) + ((e_s & f_s) ^ (~e_s & g_s)) + k_s + w_q[0];
    t2_d    = big_sig0(a_s) + ((a_s & b_s) ^ (a_s & c_s) ^ (b_s & c_s));
    round_d = {t1_d + t2_d, a_s, b_s, c_s, d_s + t1_d, e_s, f_s, g_s};
    w_new_d = small_sig1(w_q[14]) + w_q[9] + small_sig0(w_q[1]) + w_q[0];
  end

  // Block sequencing FSM with registered outputs and datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      st_q      <= 256'd0;
      cnt_q     <= 7'd0;
      block_q   <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SHA256_MIDSTATE_EN
      mid_use_q <= 1'b0;
`endif
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= 32'd0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_INIT;
            block_q   <= ~block_q;   // IV-load toggle, visible during INIT
            busy_q    <= 1'b1;
`ifdef SHA256_MIDSTATE_EN
            mid_use_q <= mid_use;
`endif
          end
        end
        S_INIT: begin
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          // h_in has had a full cycle to reflect the IV load.
`ifdef SHA256_MIDSTATE_EN
          st_q    <= mid_use_q ? mid_state : h_in;
`else
          st_q    <= h_in;
`endif
          cnt_q   <= 7'd0;
          ready_q <= 1'b1;
          state_q <= S_RECV;
        end
        S_RECV: begin
          if (msg_valid) begin
            for (int i = 0; i < 15; i++) begin
              w_q[i] <= w_q[i + 1];
            end
            w_q[15] <= msg_word;
            if (cnt_q == LAST_WORD) begin
              cnt_q   <= 7'd0;
              ready_q <= 1'b0;
              state_q <= S_RUN;
            end else begin
              cnt_q   <= cnt_q + 7'd1;
            end
          end
        end
        S_RUN: begin
          st_q <= round_d;
          for (int i = 0; i < 15; i++) begin
            w_q[i] <= w_q[i + 1];
          end
          w_q[15] <= w_new_d;
          if (cnt_q == LAST_RND) begin
            cnt_q   <= 7'd0;
            block_q <= ~block_q;     // accumulate toggle, visible during FIN
            state_q <= S_FIN;
          end else begin
            cnt_q   <= cnt_q + 7'd1;
          end
        end
        S_FIN: begin
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign msg_ready = ready_q;
  assign block     = block_q;
  assign work_out  = st_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sha256_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sha256_round_sequencer
//
// Directed self-checking bench for sha256_round_sequencer. Cycle numbers are
// relative to the cycle in which start is high (cycle 0).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sha256_round_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         msg_valid = 1'b0;
  logic [31:0]  msg_word = 32'd0;
  logic         msg_ready;
  logic [255:0] h_in = 256'd0;
  logic         block;
  logic [255:0] work_out;
  logic         busy;
  logic         done;
`ifdef SHA256_MIDSTATE_EN
  logic         mid_use = 1'b0;
  logic [255:0] mid_state = 256'd0;
`endif

  sha256_round_sequencer #(.ROUNDS(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef SHA256_MIDSTATE_EN
    .mid_use   (mid_use),
    .mid_state (mid_state),
`endif
    .msg_valid (msg_valid),
    .msg_word  (msg_word),
    .msg_ready (msg_ready),
    .h_in      (h_in),
    .block     (block),
    .work_out  (work_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] ABC_EXP = {32'h506e3058, 32'hd39a2165, 32'h04d24d6c, 32'hb85e2ce9,
                                      32'h5ef50f24, 32'hfb121210, 32'h948d25b6, 32'h961f4894};
  localparam logic [255:0] ALT_H = {32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210,
                                    32'hdeadbeef, 32'hcafef00d, 32'h0badc0de, 32'h13579bdf};

  localparam logic [31:0] K_TB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t0 = 0;
  logic [31:0] wv [16];

  // Free-running cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts block toggles and done pulses with their cycle numbers.
  logic blk_prev = 1'b0;
  int tog_total = 0;
  int tog_prev_cyc = 0;
  int tog_last_cyc = 0;
  int done_total = 0;
  int done_cyc = 0;
  always @(negedge clk) begin
    if (block !== blk_prev) begin
      tog_total    <= tog_total + 1;
      tog_prev_cyc <= tog_last_cyc;
      tog_last_cyc <= cyc;
    end
    blk_prev <= block;
    if (done === 1'b1) begin
      done_total <= done_total + 1;
      done_cyc   <= cyc;
    end
  end

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference compression of wv starting from hv; returns final {a..h}.
  function automatic logic [255:0] model(input logic [255:0] hv);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, s0, s1, x1, x2;
    for (int t = 0; t < 16; t++) w[t] = wv[t];
    for (int t = 16; t < 64; t++) begin
      s0 = ror32(w[t-15], 7) ^ ror32(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror32(w[t-2], 17) ^ ror32(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hv;
    for (int t = 0; t < 64; t++) begin
      x1 = h + (ror32(e, 6) ^ ror32(e, 11) ^ ror32(e, 25)) + ((e & f) ^ (~e & g)) + K_TB[t] + w[t];
      x2 = (ror32(a, 2) ^ ror32(a, 13) ^ ror32(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + x1; d = c; c = b; b = a; a = x1 + x2;
    end
    return {a, b, c, d, e, f, g, h};
  endfunction

  task automatic load_abc();
    for (int i = 0; i < 16; i++) wv[i] = 32'd0;
    wv[0]  = 32'h61626380;
    wv[15] = 32'h00000018;
  endtask

  // Drives one block: start, 16 words (optional stall after word 7), then waits
  // for done. extra_start pulses start at that cycle; rst_at asserts reset.
  task automatic run_block(input int stall_len, input int extra_start, input int rst_at,
                           output int ready_rel, output bit tmo);
    int idx;
    int stall_left;
    int guard;
    int base_done;
    bit acc;
    idx = 0; stall_left = stall_len; acc = 1'b0; ready_rel = -1; tmo = 1'b0;
    base_done = done_total;
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    msg_valid = 1'b1;
    msg_word = wv[0];
    guard = 0;
    while (idx < 16 && guard < 200) begin
      @(posedge clk); #1;
      start = 1'b0;
      guard++;
      if (acc) idx++;
      if (msg_ready === 1'b1 && ready_rel < 0) ready_rel = cyc - t0;
      if (idx < 16) begin
        if (idx == 8 && stall_left > 0) begin
          msg_valid = 1'b0;
          stall_left--;
        end else begin
          msg_valid = 1'b1;
          msg_word = wv[idx];
        end
      end else begin
        msg_valid = 1'b0;
      end
      acc = msg_valid && (msg_ready === 1'b1);
    end
    msg_valid = 1'b0;
    if (idx < 16) tmo = 1'b1;
    guard = 0;
    while (done_total == base_done && guard < 300 && !tmo) begin
      @(posedge clk); #1;
      guard++;
      if (rst_at > 0 && (cyc - t0) == rst_at) begin
        rst_n = 1'b0;
        break;
      end
      start = (extra_start > 0 && (cyc - t0) == extra_start);
    end
    start = 1'b0;
    if (rst_at == 0 && done_total == base_done) tmo = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (block !== 1'b0) begin n_bad++; $display("FAIL reset_block: got %b want 0", block); end
    n_cmp++; if (msg_ready !== 1'b0) begin n_bad++; $display("FAIL reset_msg_ready: got %b want 0", msg_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (work_out !== 256'd0) begin n_bad++; $display("FAIL reset_work_out: got %h want 0", work_out); end
    rst_n = 1'b1;
  endtask

  task automatic test_msg_ignored();
    @(negedge clk);
    msg_valid = 1'b1;
    msg_word = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (msg_ready !== 1'b0) begin n_bad++; $display("FAIL idle_msg_ready: got %b want 0", msg_ready); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    msg_valid = 1'b0;
  endtask

  task automatic test_abc();
    int rr; bit tmo; int tb; int db; logic [31:0] h7;
    load_abc();
    h_in = IV;
    tb = tog_total; db = done_total;
    run_block(0, 0, 0, rr, tmo);
    n_cmp++; if (tmo) begin n_bad++; $display("FAIL abc_timeout: got timeout want done"); end
    n_cmp++; if (rr !== 3) begin n_bad++; $display("FAIL abc_ready_cycle: got %0d want 3", rr); end
    n_cmp++; if (work_out !== ABC_EXP) begin n_bad++; $display("FAIL abc_work_out: got %h want %h", work_out, ABC_EXP); end
    n_cmp++; if (done_cyc - t0 !== 84) begin n_bad++; $display("FAIL abc_done_cycle: got %0d want 84", done_cyc - t0); end
    n_cmp++; if (tog_total - tb !== 2) begin n_bad++; $display("FAIL abc_toggle_count: got %0d want 2", tog_total - tb); end
    n_cmp++; if (tog_prev_cyc - t0 !== 1) begin n_bad++; $display("FAIL abc_toggle1_cycle: got %0d want 1", tog_prev_cyc - t0); end
    n_cmp++; if (tog_last_cyc - t0 !== 83) begin n_bad++; $display("FAIL abc_toggle2_cycle: got %0d want 83", tog_last_cyc - t0); end
    h7 = IV[31:0] + work_out[31:0];
    n_cmp++; if (h7 !== 32'hf20015ad) begin n_bad++; $display("FAIL abc_h7: got %h want f20015ad", h7); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abc_busy_after: got %b want 0", busy); end
    n_cmp++; if (done_total - db !== 1) begin n_bad++; $display("FAIL abc_done_width: got %0d want 1", done_total - db); end
  endtask

  task automatic test_stall();
    int rr; bit tmo;
    load_abc();
    h_in = IV;
    run_block(5, 0, 0, rr, tmo);
    n_cmp++; if (tmo) begin n_bad++; $display("FAIL stall_timeout: got timeout want done"); end
    n_cmp++; if (work_out !== ABC_EXP) begin n_bad++; $display("FAIL stall_work_out: got %h want %h", work_out, ABC_EXP); end
    n_cmp++; if (done_cyc - t0 !== 89) begin n_bad++; $display("FAIL stall_done_cycle: got %0d want 89", done_cyc - t0); end
  endtask

  task automatic test_start_during_run();
    int rr; bit tmo; int tb;
    load_abc();
    h_in = IV;
    tb = tog_total;
    run_block(0, 40, 0, rr, tmo);
    n_cmp++; if (work_out !== ABC_EXP) begin n_bad++; $display("FAIL busy_start_work_out: got %h want %h", work_out, ABC_EXP); end
    n_cmp++; if (done_cyc - t0 !== 84) begin n_bad++; $display("FAIL busy_start_done_cycle: got %0d want 84", done_cyc - t0); end
    repeat (5) @(negedge clk);
    n_cmp++; if (tog_total - tb !== 2) begin n_bad++; $display("FAIL busy_start_toggles: got %0d want 2", tog_total - tb); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_start_no_queue: got %b want 0", busy); end
  endtask

  task automatic test_zero_block();
    int rr; bit tmo; logic [255:0] exp;
    for (int i = 0; i < 16; i++) wv[i] = 32'd0;
    h_in = IV;
    exp = model(IV);
    run_block(0, 0, 0, rr, tmo);
    n_cmp++; if (work_out !== exp) begin n_bad++; $display("FAIL zero_work_out: got %h want %h", work_out, exp); end
    n_cmp++; if (IV[31:0] + work_out[31:0] !== 32'h5be0cd19 + exp[31:0]) begin
      n_bad++; $display("FAIL zero_h7: got %h want %h", IV[31:0] + work_out[31:0], 32'h5be0cd19 + exp[31:0]); end
    for (int i = 0; i < 16; i++) wv[i] = 32'h9e3779b9 * (i + 1);
    h_in = ALT_H;
    exp = model(ALT_H);
    run_block(0, 0, 0, rr, tmo);
    n_cmp++; if (work_out !== exp) begin n_bad++; $display("FAIL alt_work_out: got %h want %h", work_out, exp); end
  endtask

  task automatic test_reset_mid_run();
    int rr; bit tmo;
    load_abc();
    h_in = IV;
    run_block(0, 0, 40, rr, tmo);
    #1;
    n_cmp++; if (block !== 1'b0) begin n_bad++; $display("FAIL midrst_block: got %b want 0", block); end
    n_cmp++; if (msg_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_msg_ready: got %b want 0", msg_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b want 0", done); end
    n_cmp++; if (work_out !== 256'd0) begin n_bad++; $display("FAIL midrst_work_out: got %h want 0", work_out); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_block(0, 0, 0, rr, tmo);
    n_cmp++; if (tmo) begin n_bad++; $display("FAIL midrst_after_timeout: got timeout want done"); end
    n_cmp++; if (work_out !== ABC_EXP) begin n_bad++; $display("FAIL midrst_after_work_out: got %h want %h", work_out, ABC_EXP); end
    n_cmp++; if (done_cyc - t0 !== 84) begin n_bad++; $display("FAIL midrst_after_done_cycle: got %0d want 84", done_cyc - t0); end
  endtask

`ifdef SHA256_MIDSTATE_EN
  task automatic test_midstate();
    int rr; bit tmo; logic [255:0] exp;
    load_abc();
    h_in = ALT_H;
    mid_state = IV;
    mid_use = 1'b1;
    run_block(0, 0, 0, rr, tmo);
    mid_use = 1'b0;
    n_cmp++; if (work_out !== ABC_EXP) begin n_bad++; $display("FAIL mid_use1_work_out: got %h want %h", work_out, ABC_EXP); end
    exp = model(ALT_H);
    run_block(0, 0, 0, rr, tmo);
    n_cmp++; if (work_out !== exp) begin n_bad++; $display("FAIL mid_use0_work_out: got %h want %h", work_out, exp); end
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_msg_ignored();
    test_abc();
    test_stall();
    test_start_during_run();
    test_zero_block();
    test_reset_mid_run();
`ifdef SHA256_MIDSTATE_EN
    test_midstate();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
